// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB-first, one full-adder cell plus a registered carry.
// Optional signed-overflow output `ovf` when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            sum_bit;
    logic            maj;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sum_bit = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign maj     = (a_sr_q[0] & b_sr_q[0]) |
                     (a_sr_q[0] & carry_q) |
                     (b_sr_q[0] & carry_q);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath updates follow the same state decode
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b ^ {WIDTH{sub}};
                    carry_d  = sub;
                    cnt_d    = '0;
                    result_d = '0;
                end
            end
            ST_RUN: begin
                carry_d  = maj;
                result_d = {sum_bit, result_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d = maj;
                    // carry into MSB vs carry out of MSB
                    ovf_d  = carry_q ^ maj;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf    = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
